mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port program/data RAM between the CPU controller (fetch, LDR/STR) and a
//  debug/loader port (program load, memory inspect). Arbitrates requests, sequences each RAM
//  access, and returns a one-cycle ack. Sits between controller/counter and RAM in top.
// PARAMETERS
//  DATA_W        16  RAM word width
//  ADDR_W        8   RAM address width
//  STARVE_LIMIT  4   consecutive CPU grants tolerated while dbg waits (fairness build only)
// PORTS
//  clk           in   1       rising-edge clock (single domain)
//  reset         in   1       synchronous, active-high
//  cpu_req       in   1       CPU access request; held until cpu_ack
//  cpu_write     in   1       1 = write, 0 = read
//  cpu_addr      in   ADDR_W  CPU address
//  cpu_wdata     in   DATA_W  CPU write data
//  cpu_ack       out  1       one-cycle completion pulse; read data valid this cycle
//  dbg_req/dbg_write/dbg_addr/dbg_wdata/dbg_ack  as cpu_* for the debug port
//  dbg_lock      in   1       1 = CPU requests not granted (CPU halted for load)
//  rdata         out  DATA_W  = mem_rdata; meaningful only while cpu_ack or dbg_ack
//  mem_addr      out  ADDR_W  RAM read/write address (registered)
//  mem_wdata     out  DATA_W  RAM write data (registered)
//  mem_write     out  1       RAM write enable (registered)
//  mem_rdata     in   DATA_W  RAM read data, valid 1 cycle after mem_addr
//  busy          out  1       state != IDLE
//  grant_id      out  1       0 = CPU, 1 = dbg; owner of current/last access
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; starve counter 0. Reset mid-access aborts it: no ack,
//    mem_write 0 from the next cycle.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE, unconditional after IDLE.
//    IDLE: if a grantable request, latch addr/wdata/write of winner into mem_*, set grant_id,
//    go ACCESS. Else stay; mem_write 0.
//    ACCESS (1 cycle): mem_write = latched write; RAM samples on the closing edge.
//    RESP (1 cycle): winner's ack = 1; rdata valid for reads; mem_write 0; go IDLE.
//  - Latency: req seen high at edge E -> ack high in cycle E+2. Max rate: 1 access/3 cycles.
//  - Requests are sampled only in IDLE. A requester drops req at the edge ending its ack
//    cycle, or keeps it high to issue the next access.
//  - Priority: CPU over dbg. Exception: dbg_lock = 1 makes CPU ungrantable. An in-flight CPU
//    access still completes. dbg_lock rising mid-access has no effect until IDLE.
//  - Simultaneous cpu_req & dbg_req in IDLE: CPU wins, unless dbg_lock = 1 or fairness forces dbg.
//  - Only one ack is ever high in a cycle. An ack is never issued without a prior grant.
//  - Addresses are used as-is; no wrap or bounds logic (RAM is 2^ADDR_W deep).
// CONFIGURATION
//  MEM_ARB_FAIRNESS_EN defined:
//    - Starve counter increments on each CPU grant while dbg_req = 1, saturating at
//      STARVE_LIMIT.
//    - At STARVE_LIMIT, the next IDLE arbitration grants dbg even if cpu_req = 1; counter
//      clears.
//    - Counter also clears on any dbg grant and whenever dbg_req = 0.
//  Undefined: strict CPU priority; dbg may starve unless dbg_lock is used. No counter logic.
// STRUCTURE
//  mem_arb_pkg: state encoding (IDLE, ACCESS, RESP) and GRANT_CPU = 0, GRANT_DBG = 1.
//  Sub-module mem_arb_starve_ctr: counter and force_dbg output, instantiated only under
//  MEM_ARB_FAIRNESS_EN. FSM, request latch and output regs stay in mem_arbiter.
// TESTING
//  1 CPU read: mem[0x10] = 0xBEEF, cpu_req at edge 0 addr 0x10 -> cpu_ack and rdata = 0xBEEF
//    at cycle 2 only; busy high cycles 1-2.
//  2 dbg write: dbg_req, write, addr 0x22, wdata 0x1234 -> mem_write = 1 exactly in cycle 1,
//    dbg_ack cycle 2; later CPU read of 0x22 returns 0x1234.
//  3 Simultaneous reqs, dbg_lock = 0, fairness off -> CPU granted first, dbg ack 3 cycles
//    after CPU ack; grant_id 0 then 1.
//  4 dbg_lock = 1 with cpu_req and dbg_req both held -> only dbg_ack pulses; cpu_ack stays 0
//    until lock drops.
//  5 MEM_ARB_FAIRNESS_EN, STARVE_LIMIT = 4, both reqs held continuously -> grant pattern
//    C,C,C,C,D repeating; without the macro, all C.
//  6 reset asserted during ACCESS of a CPU write -> no cpu_ack; all outputs 0 the cycle after
//    reset; FSM in IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the RAM arbiter: FSM state encoding and grant owner codes.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DBG = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: CPU port, debug/loader port, shared read data and status.
interface mem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) ();
  logic              cpu_req;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              dbg_req;
  logic              dbg_write;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic              dbg_lock;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              grant_id;

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata,
    output dbg_req, dbg_write, dbg_addr, dbg_wdata, dbg_lock,
    input  cpu_ack, dbg_ack, rdata, busy, grant_id
  );

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_write, dbg_addr, dbg_wdata, dbg_lock,
    output cpu_ack, dbg_ack, rdata, busy, grant_id
  );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts CPU grants taken while the debug port waits; force_dbg hands the next slot to debug.
module mem_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dbg_req,
  input  logic grant_cpu,
  input  logic grant_dbg,
  output logic force_dbg
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!dbg_req || grant_dbg)
      cnt_d = '0;
    else if (grant_cpu && (cnt_q != CNT_W'(STARVE_LIMIT)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign force_dbg = (cnt_q == CNT_W'(STARVE_LIMIT));
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between CPU and debug/loader: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Optional debug-starvation fairness is built when MEM_ARB_FAIRNESS_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_write_q, mem_write_d;
  logic              grant_id_q, grant_id_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;

  logic cpu_ok, pick_dbg, pick_cpu;
  logic grant_cpu, grant_dbg, force_dbg;

  // dbg_lock only blocks new CPU grants; an access already latched always runs to completion.
  assign cpu_ok   = bus.cpu_req & ~bus.dbg_lock;
  assign pick_dbg = bus.dbg_req & (~cpu_ok | force_dbg);
  assign pick_cpu = cpu_ok & ~pick_dbg;

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;
    grant_id_d  = grant_id_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    grant_cpu   = 1'b0;
    grant_dbg   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_cpu = pick_cpu;
        grant_dbg = pick_dbg;
        if (pick_cpu || pick_dbg) begin
          state_d     = ST_ACCESS;
          grant_id_d  = pick_dbg ? GRANT_DBG : GRANT_CPU;
          mem_addr_d  = pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
          mem_wdata_d = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
          mem_write_d = pick_dbg ? bus.dbg_write : bus.cpu_write;
        end
      end
      ST_ACCESS: begin
        state_d   = ST_RESP;
        cpu_ack_d = (grant_id_q == GRANT_CPU);
        dbg_ack_d = (grant_id_q == GRANT_DBG);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      grant_id_q  <= GRANT_CPU;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      grant_id_q  <= grant_id_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
    end
  end

`ifdef MEM_ARB_FAIRNESS_EN
  mem_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (clk),
    .reset     (reset),
    .dbg_req   (bus.dbg_req),
    .grant_cpu (grant_cpu),
    .grant_dbg (grant_dbg),
    .force_dbg (force_dbg)
  );
`else
  // Strict CPU priority: grant pulses have no consumer.
  logic unused_fair;
  assign force_dbg   = 1'b0;
  assign unused_fair = grant_cpu ^ grant_dbg ^ (STARVE_LIMIT > 0);
`endif

  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_write    = mem_write_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.dbg_ack  = dbg_ack_q;
  assign bus.rdata    = mem_rdata;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.grant_id = grant_id_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_write;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  // RAM: synchronous read, one cycle after the address
  logic [DATA_W-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Model: each access is a grant timestamp; ack two cycles later, next grant three edges later.
  int                cyc        = 0;
  int                last_grant = -100;
  int                starve     = 0;
  bit                g_id, g_wr, g_rvalid;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata, g_rdata;
  logic [DATA_W-1:0] shadow [0:255];
  bit                written [0:255];

  task automatic model_edge();
    bit cpu_ok, take_dbg, take_cpu;
    cyc++;
    if (reset) begin
      last_grant = -100; starve = 0;
      g_id = 0; g_wr = 0; g_addr = '0; g_wdata = '0;
      return;
    end
    cpu_ok   = bus.cpu_req && !bus.dbg_lock;
    take_dbg = 0;
    take_cpu = 0;
    if (cyc - last_grant >= 3) begin
`ifdef MEM_ARB_FAIRNESS_EN
      take_dbg = bus.dbg_req && (!cpu_ok || starve == LIMIT);
`else
      take_dbg = bus.dbg_req && !cpu_ok;
`endif
      take_cpu = cpu_ok && !take_dbg;
    end
    if (take_dbg || take_cpu) begin
      last_grant = cyc;
      g_id    = take_dbg;
      g_wr    = take_dbg ? bus.dbg_write : bus.cpu_write;
      g_addr  = take_dbg ? bus.dbg_addr  : bus.cpu_addr;
      g_wdata = take_dbg ? bus.dbg_wdata : bus.cpu_wdata;
      if (g_wr) begin
        shadow[g_addr]  = g_wdata;
        written[g_addr] = 1;
      end else begin
        g_rdata  = shadow[g_addr];
        g_rvalid = written[g_addr];
      end
    end
    if (!bus.dbg_req || take_dbg) starve = 0;
    else if (take_cpu && starve < LIMIT) starve++;
  endtask

  task automatic check_outputs();
    int d = cyc - last_grant;
    chk("busy",      32'(bus.busy),    32'(d == 0 || d == 1));
    chk("cpu_ack",   32'(bus.cpu_ack), 32'(d == 1 && !g_id));
    chk("dbg_ack",   32'(bus.dbg_ack), 32'(d == 1 && g_id));
    chk("mem_write", 32'(mem_write),   32'(d == 0 && g_wr));
    chk("grant_id",  32'(bus.grant_id), 32'(g_id));
    chk("mem_addr",  32'(mem_addr),    32'(g_addr));
    chk("mem_wdata", 32'(mem_wdata),   32'(g_wdata));
    if (d == 1 && !g_wr && g_rvalid) chk("rdata", 32'(bus.rdata), 32'(g_rdata));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic new_cpu();
    bus.cpu_req   = 1'b1;
    bus.cpu_write = 1'($urandom % 2);
    bus.cpu_addr  = ADDR_W'($urandom_range(0, 63));
    bus.cpu_wdata = DATA_W'($urandom);
  endtask

  task automatic new_dbg();
    bus.dbg_req   = 1'b1;
    bus.dbg_write = 1'($urandom % 2);
    bus.dbg_addr  = ADDR_W'($urandom_range(0, 63));
    bus.dbg_wdata = DATA_W'($urandom);
  endtask

  // One cycle; on ack a requester either reissues (hold) or drops its request.
  task automatic step(input bit rnd, input bit hold);
    tick();
    if (bus.cpu_ack) begin
      if (rnd ? ($urandom % 2 == 1) : hold) new_cpu(); else bus.cpu_req = 1'b0;
    end else if (rnd && !bus.cpu_req && $urandom % 3 == 0) new_cpu();
    if (bus.dbg_ack) begin
      if (rnd ? ($urandom % 2 == 1) : hold) new_dbg(); else bus.dbg_req = 1'b0;
    end else if (rnd && !bus.dbg_req && $urandom % 3 == 0) new_dbg();
    if (rnd && $urandom % 16 == 0) bus.dbg_lock = !bus.dbg_lock;
  endtask

  // Single access; returns cycles to ack and leaves the arbiter idle for the next edge.
  task automatic access(input bit port, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, output int lat, output logic [DATA_W-1:0] rd);
    bit got = 0;
    if (port) begin
      bus.dbg_req = 1'b1; bus.dbg_write = wr; bus.dbg_addr = addr; bus.dbg_wdata = wd;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_write = wr; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
    lat = 0;
    rd  = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      lat++;
      got = port ? bus.dbg_ack : bus.cpu_ack;
    end
    chk("ack_seen", 32'(got), 32'd1);
    rd = bus.rdata;
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    tick();
  endtask

  initial begin
    int lat, c_at, d_at, n_c, n_d;
    logic [DATA_W-1:0] rd;
    bit seq [$];

    reset = 1'b1;
    bus.cpu_req = 0; bus.cpu_write = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_write = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.dbg_lock = 0;
    tick();
    tick();
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_ack",    32'(bus.cpu_ack | bus.dbg_ack), 32'd0);
    chk("rst_mw",     32'(mem_write), 32'd0);
    chk("rst_addr",   32'(mem_addr), 32'd0);
    reset = 1'b0;

    // Preload via the loader port
    for (int a = 0; a < 64; a++)
      access(1'b1, 1'b1, ADDR_W'(a), (a == 16) ? 16'hBEEF : DATA_W'($urandom), lat, rd);

    // CPU read, fixed latency
    access(1'b0, 1'b0, 8'h10, '0, lat, rd);
    chk("t1_lat", 32'(lat), 32'd2);
    chk("t1_rdata", 32'(rd), 32'hBEEF);

    // dbg write: mem_write only in the access cycle
    bus.dbg_req = 1; bus.dbg_write = 1; bus.dbg_addr = 8'h22; bus.dbg_wdata = 16'h1234;
    tick();
    chk("t2_mw_c1", 32'(mem_write), 32'd1);
    tick();
    chk("t2_ack", 32'(bus.dbg_ack), 32'd1);
    chk("t2_mw_c2", 32'(mem_write), 32'd0);
    bus.dbg_req = 0;
    tick();
    access(1'b0, 1'b0, 8'h22, '0, lat, rd);
    chk("t2_rdback", 32'(rd), 32'h1234);

    // Simultaneous requests: CPU first, dbg three cycles later
    bus.cpu_req = 1; bus.cpu_write = 0; bus.cpu_addr = 8'h05;
    bus.dbg_req = 1; bus.dbg_write = 0; bus.dbg_addr = 8'h06;
    c_at = -1; d_at = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.cpu_ack) begin c_at = i; chk("t3_gid_c", 32'(bus.grant_id), 32'd0); bus.cpu_req = 0; end
      if (bus.dbg_ack) begin d_at = i; chk("t3_gid_d", 32'(bus.grant_id), 32'd1); bus.dbg_req = 0; end
    end
    chk("t3_cpu_at", 32'(c_at), 32'd1);
    chk("t3_gap", 32'(d_at - c_at), 32'd3);

    // dbg_lock: only dbg served while both held
    bus.dbg_lock = 1; new_cpu(); new_dbg();
    n_c = 0; n_d = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1);
      n_c += int'(bus.cpu_ack);
      n_d += int'(bus.dbg_ack);
    end
    chk("t4_cpu_acks", 32'(n_c), 32'd0);
    chk("t4_dbg_acks", 32'(n_d), 32'd4);
    bus.dbg_lock = 0; bus.dbg_req = 0;
    n_c = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      n_c += int'(bus.cpu_ack);
    end
    chk("t4_unlock", 32'(n_c), 32'd1);

    // Both held continuously: grant sequence
    new_cpu(); new_dbg();
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1);
      if (bus.cpu_ack) seq.push_back(1'b0);
      if (bus.dbg_ack) seq.push_back(1'b1);
    end
    bus.cpu_req = 0; bus.dbg_req = 0;
    chk("t5_count", 32'(seq.size()), 32'd10);
    foreach (seq[i]) begin
`ifdef MEM_ARB_FAIRNESS_EN
      chk("t5_pattern", 32'(seq[i]), 32'(i % 5 == 4));
`else
      chk("t5_pattern", 32'(seq[i]), 32'd0);
`endif
    end
    tick();

    // Reset during the access cycle of a CPU write
    bus.cpu_req = 1; bus.cpu_write = 1; bus.cpu_addr = 8'h30; bus.cpu_wdata = 16'hAAAA;
    tick();
    chk("t6_mw", 32'(mem_write), 32'd1);
    reset = 1; bus.cpu_req = 0;
    tick();
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_ack",  32'(bus.cpu_ack), 32'd0);
    chk("t6_mw0",  32'(mem_write), 32'd0);
    chk("t6_gid",  32'(bus.grant_id), 32'd0);
    chk("t6_addr", 32'(mem_addr), 32'd0);
    reset = 0;
    tick();
    chk("t6_noack", 32'(bus.cpu_ack), 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) step(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
